// File: rtl/lut_mult_sequencer_if.sv
// Start/operand handshake plus the A_Poly/B -> D_in_* loop through the LUT partial-product stage.
// master = host side (drives start, operands and LUT results); slave = the sequencer.
interface lut_mult_sequencer_if;
    logic         start;
    logic [63:0]  A_in;
    logic [63:0]  B_in;
    logic         ready;
    logic [63:0]  A_Poly;
    logic [63:0]  B;
    logic [127:0] D_in_1;
    logic [127:0] D_in_2;
    logic [127:0] product;
    logic         done;

    modport master (
        output start, A_in, B_in, D_in_1, D_in_2,
        input  ready, A_Poly, B, product, done
    );

    modport slave (
        input  start, A_in, B_in, D_in_1, D_in_2,
        output ready, A_Poly, B, product, done
    );
endinterface

// File: rtl/lut_mult_sequencer.sv
// Byte-pair sequencer/XOR accumulator around the LUT stage of a 64x64 carry-less multiplier.
// done pulses 4+LUT_LAT edges after the accepting start edge; start is ignored while ready=0.
module lut_mult_sequencer #(
    parameter int LUT_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    lut_mult_sequencer_if.slave  ifc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]   state_q,     state_d;
    logic [1:0]   idx_q,       idx_d;
    logic [63:0]  a_reg_q,     a_reg_d;
    logic [63:0]  b_q,         b_d;
    logic [63:0]  a_poly_q,    a_poly_d;
    logic [127:0] acc_q,       acc_d;
    logic [127:0] product_q,   product_d;
    logic         done_q,      done_d;
    logic         pipe_vld_q,  pipe_vld_d;
    logic         pipe_last_q, pipe_last_d;

    logic         issue_en;
    logic         issue_last;
    logic         acc_en;
    logic         acc_last;
    logic [127:0] partial;

    // Byte pair i of A with its byte positions 2i (lo) and 2i+1 (hi).
    function automatic logic [63:0] pair_word(input logic [63:0] a, input logic [1:0] i);
        logic [15:0] pair;
        pair = a[{i, 4'b0000} +: 16];
        return {40'b0, {1'b0, i, 1'b1}, pair[15:8], {1'b0, i, 1'b0}, pair[7:0]};
    endfunction

    assign issue_en   = (state_q == S_ISSUE);
    assign issue_last = issue_en && (idx_q == 2'd3);

    // With a registered LUT the returned partial products trail the issue by one cycle.
    assign acc_en   = (LUT_LAT == 0) ? issue_en   : pipe_vld_q;
    assign acc_last = (LUT_LAT == 0) ? issue_last : pipe_last_q;
    assign partial  = acc_q ^ ifc.D_in_1 ^ ifc.D_in_2;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_reg_d     = a_reg_q;
        b_d         = b_q;
        a_poly_d    = a_poly_q;
        acc_d       = acc_q;
        product_d   = product_q;
        done_d      = 1'b0;
        pipe_vld_d  = issue_en;
        pipe_last_d = issue_last;

        if (acc_en) begin
            acc_d = partial;
        end
        if (acc_last) begin
            product_d = partial;
            done_d    = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (ifc.start) begin
                    state_d  = S_ISSUE;
                    idx_d    = 2'd0;
                    a_reg_d  = ifc.A_in;
                    b_d      = ifc.B_in;
                    acc_d    = '0;
                    a_poly_d = pair_word(ifc.A_in, 2'd0);
                end
            end
            S_ISSUE: begin
                if (idx_q == 2'd3) begin
                    state_d  = (LUT_LAT == 0) ? S_IDLE : S_WAIT;
                    idx_d    = 2'd0;
                    a_poly_d = '0;
                end else begin
                    idx_d    = idx_q + 2'd1;
                    a_poly_d = pair_word(a_reg_q, idx_q + 2'd1);
                end
            end
            S_WAIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                idx_d    = 2'd0;
                a_poly_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            a_reg_q     <= '0;
            b_q         <= '0;
            a_poly_q    <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            done_q      <= 1'b0;
            pipe_vld_q  <= 1'b0;
            pipe_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_reg_q     <= a_reg_d;
            b_q         <= b_d;
            a_poly_q    <= a_poly_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            done_q      <= done_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
        end
    end

    assign ifc.ready   = (state_q == S_IDLE);
    assign ifc.A_Poly  = a_poly_q;
    assign ifc.B       = b_q;
    assign ifc.product = product_q;
    assign ifc.done    = done_q;

endmodule

// File: tb/tb_lut_mult_sequencer.sv
// Scoreboard bench: one DUT per LUT latency (0 and 1), each with a behavioural LUT stage.
module tb_lut_mult_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a_in;
    logic [63:0] b_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pend [2];

    logic [1:0]   rdy_w;
    logic [1:0]   done_w;
    logic [127:0] prod_w  [2];
    logic [63:0]  apoly_w [2];
    logic [63:0]  bout_w  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] clmul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (b[i]) r = r ^ ({64'b0, a} << i);
        return r;
    endfunction

    function automatic logic [127:0] lut_d(input logic [63:0] ap, input logic [63:0] b, input bit hi);
        logic [7:0] bt;
        logic [3:0] pos;
        bt  = hi ? ap[19:12] : ap[7:0];
        pos = hi ? ap[23:20] : ap[11:8];
        return clmul({56'b0, bt}, b) << (int'(pos) * 8);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        lut_mult_sequencer_if ifc();
        logic [127:0] d1;
        logic [127:0] d2;
        logic [127:0] exp_q [$];
        int           acc_cyc_q [$];
        logic         prev_done;

        assign ifc.start  = start;
        assign ifc.A_in   = a_in;
        assign ifc.B_in   = b_in;
        assign ifc.D_in_1 = d1;
        assign ifc.D_in_2 = d2;

        if (g == 0) begin : g_comb
            always_comb begin
                d1 = lut_d(ifc.A_Poly, ifc.B, 1'b1);
                d2 = lut_d(ifc.A_Poly, ifc.B, 1'b0);
            end
        end else begin : g_reg
            always @(posedge clk) begin
                d1 <= lut_d(ifc.A_Poly, ifc.B, 1'b1);
                d2 <= lut_d(ifc.A_Poly, ifc.B, 1'b0);
            end
        end

        lut_mult_sequencer #(.LUT_LAT(g)) dut (
            .clk (clk),
            .rst (rst),
            .ifc (ifc)
        );

        assign rdy_w[g]   = ifc.ready;
        assign done_w[g]  = ifc.done;
        assign prod_w[g]  = ifc.product;
        assign apoly_w[g] = ifc.A_Poly;
        assign bout_w[g]  = ifc.B;

        initial prev_done = 1'b0;

        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
                acc_cyc_q.delete();
                pend[g]   = 0;
                prev_done = 1'b0;
            end else begin
                if (ifc.done) begin
                    chk($sformatf("lat%0d_done_width", g), {127'b0, prev_done}, 128'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL lat%0d_unexpected_done: got product %h expected no done", g, ifc.product);
                    end else begin
                        chk($sformatf("lat%0d_product", g), ifc.product, exp_q.pop_front());
                        chk($sformatf("lat%0d_latency", g), 128'(cyc - acc_cyc_q.pop_front()), 128'(4 + g));
                        pend[g]--;
                    end
                end
                if (ifc.start && ifc.ready) begin
                    exp_q.push_back(clmul(ifc.A_in, ifc.B_in));
                    acc_cyc_q.push_back(cyc + 1);
                    pend[g]++;
                end
                prev_done = ifc.done;
            end
        end
    end

    task automatic reset_checks(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_ready%0d", tag, g),   {127'b0, rdy_w[g]},  128'd1);
            chk($sformatf("%s_done%0d", tag, g),    {127'b0, done_w[g]}, 128'd0);
            chk($sformatf("%s_product%0d", tag, g), prod_w[g],           128'd0);
            chk($sformatf("%s_apoly%0d", tag, g),   {64'b0, apoly_w[g]}, 128'd0);
            chk($sformatf("%s_b%0d", tag, g),       {64'b0, bout_w[g]},  128'd0);
        end
    endtask

    // Leaves the bench just after the accepting edge with start already dropped.
    task automatic pulse(input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (rdy_w != 2'b11 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready %b expected 11", rdy_w);
        end
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rdy_w == 2'b11 && pend[0] == 0 && pend[1] == 0) && n < 50);
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got pending %0d/%0d expected 0/0", pend[0], pend[1]);
        end
    endtask

    task automatic op(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp, input string nm);
        pulse(a, b);
        wait_idle();
        chk({nm, "_lat0"}, prod_w[0], exp);
        chk({nm, "_lat1"}, prod_w[1], exp);
    endtask

    logic [23:0] ap_tab [4] = '{24'h102001, 24'h304203, 24'h506405, 24'h708607};

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        reset_checks("rst");
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        reset_checks("post_rst");

        // Pair sequencing on both instances: issue timing is independent of LUT latency.
        pulse(64'h0807060504030201, 64'h55);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("apoly_idx%0d_lat0", i), {64'b0, apoly_w[0]}, {104'b0, ap_tab[i]});
            chk($sformatf("apoly_idx%0d_lat1", i), {64'b0, apoly_w[1]}, {104'b0, ap_tab[i]});
        end
        chk("b_out", {64'b0, bout_w[0]}, 128'h55);
        @(negedge clk);
        chk("apoly_after_lat0", {64'b0, apoly_w[0]}, 128'd0);
        chk("apoly_after_lat1", {64'b0, apoly_w[1]}, 128'd0);
        wait_idle();

        op(64'd3, 64'd3, 128'h5, "p_3x3");
        op(64'h8000000000000000, 64'h8000000000000000, 128'h4000_0000_0000_0000_0000_0000_0000_0000, "p_msb");
        op(64'hFFFFFFFFFFFFFFFF, 64'd1, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, "p_ones");

        // A second start while busy must be dropped.
        pulse(64'h5, 64'h3);
        start = 1'b1;
        a_in  = 64'hFFFFFFFFFFFFFFFF;
        b_in  = 64'hFFFFFFFFFFFFFFFF;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        chk("ignore_lat0", prod_w[0], 128'hF);
        chk("ignore_lat1", prod_w[1], 128'hF);

        // start held: each instance takes the second operands as soon as it is idle.
        @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = 64'h100;
        b_in  = 64'hFF;
        @(posedge clk);
        #1;
        a_in  = 64'h2;
        b_in  = 64'h81;
        repeat (6) @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        chk("b2b_lat0", prod_w[0], 128'h102);
        chk("b2b_lat1", prod_w[1], 128'h102);

        // Abort during idx 2.
        pulse(64'h1234_5678_9ABC_DEF0, 64'h0F0F);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("abort_product%0d", g), prod_w[g], 128'd0);
            chk($sformatf("abort_ready%0d", g), {127'b0, rdy_w[g]}, 128'd1);
            chk($sformatf("abort_apoly%0d", g), {64'b0, apoly_w[g]}, 128'd0);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_nodone_product0", prod_w[0], 128'd0);
        chk("abort_nodone_product1", prod_w[1], 128'd0);
        op(64'd3, 64'd3, 128'h5, "after_abort");

        for (int k = 0; k < 1000; k++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            int gap;
            ra  = {$urandom(), $urandom()};
            rb  = {$urandom(), $urandom()};
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(posedge clk);
            pulse(ra, rb);
        end
        wait_idle();
        chk("drain_lat0", 128'(pend[0]), 128'd0);
        chk("drain_lat1", 128'(pend[1]), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
